// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline stage with optional skid entry and flush
// Optional stall/flush counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_skid_stage #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 32,
   parameter int SKID   = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`endif
);

   // Encoding equals the number of held entries, so occupancy is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic              main_valid;
   logic              in_fire;
   logic              out_fire;

   assign main_valid = (state_q != EMPTY);
   assign in_ready   = (SKID != 0) ? (state_q != FULL) : (out_ready | ~main_valid);
   assign in_fire    = in_valid & in_ready;
   assign out_fire   = main_valid & out_ready;
   assign out_valid  = main_valid;
   assign out_ctrl   = main_valid ? main_ctrl_q : '0;
   assign out_data   = main_data_q;
   assign occupancy  = state_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_ctrl_d = in_ctrl;
               main_data_d = in_data;
               state_d     = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_ctrl_d = in_ctrl;
               main_data_d = in_data;
            end else if (in_fire && (SKID != 0)) begin
               skid_ctrl_d = in_ctrl;
               skid_data_d = in_data;
               state_d     = FULL;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               main_ctrl_d = skid_ctrl_q;
               main_data_d = skid_data_q;
               skid_ctrl_d = '0;
               skid_data_d = '0;
               state_d     = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush drops held entries and any accepted input beat alike.
      if (flush) begin
         state_d     = EMPTY;
         main_ctrl_d = '0;
         main_data_d = '0;
         skid_ctrl_d = '0;
         skid_data_d = '0;
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (main_valid && !out_ready && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (flush && (flush_cnt != 16'hFFFF))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

   stall_stable: assert property (@(posedge CLK) disable iff (RESET)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_ctrl) && $stable(out_data)));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - scoreboard bench for pipe_skid_stage (SKID=1 and SKID=0 instances)
module tb_pipe_skid_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        iv, ir, ov, ordy;
   logic [31:0] ic, id, oc, od;
   logic [1:0]  occ;
   logic        iv0, ir0, ov0, ordy0;
   logic [31:0] ic0, id0, oc0, od0;
   logic [1:0]  occ0;
`ifdef PIPE_STAGE_STATS_EN
   logic [15:0] stall_cnt, flush_cnt, stall_cnt0, flush_cnt0;
`endif

   logic [63:0] q1[$];
   logic [63:0] q0[$];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_skid_stage #(.DATA_W(32), .CTRL_W(32), .SKID(1)) dut (
      .CLK(clk), .RESET(rst), .flush(flush),
      .in_valid(iv), .in_ready(ir), .in_ctrl(ic), .in_data(id),
      .out_valid(ov), .out_ready(ordy), .out_ctrl(oc), .out_data(od),
      .occupancy(occ)
`ifdef PIPE_STAGE_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   pipe_skid_stage #(.DATA_W(32), .CTRL_W(32), .SKID(0)) dut0 (
      .CLK(clk), .RESET(rst), .flush(1'b0),
      .in_valid(iv0), .in_ready(ir0), .in_ctrl(ic0), .in_data(id0),
      .out_valid(ov0), .out_ready(ordy0), .out_ctrl(oc0), .out_data(od0),
      .occupancy(occ0)
`ifdef PIPE_STAGE_STATS_EN
      , .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Presents one beat to the SKID=1 instance and records it once accepted.
   task automatic send(input logic [31:0] c, input logic [31:0] d);
      bit done = 0;
      iv = 1'b1; ic = c; id = d;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (ir) begin
            @(posedge clk);
            q1.push_back({c, d});
            #1;
            done = 1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) chk("send_timeout", 64'd0, 64'd1);
      iv = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (!ov) chk("idle_ctrl_zero", {32'd0, oc}, 64'd0);
         if (ov && ordy) begin
            if (q1.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_beat got ctrl=%0h data=%0h required none", oc, od);
            end else begin
               logic [63:0] e;
               e = q1.pop_front();
               chk("out_beat", {oc, od}, e);
            end
         end
         if (ov0 && ordy0) begin
            if (q0.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_beat0 got ctrl=%0h data=%0h required none", oc0, od0);
            end else begin
               logic [63:0] e;
               e = q0.pop_front();
               chk("out_beat0", {oc0, od0}, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0;
      iv = 1'b0; ic = '0; id = '0; ordy = 1'b0;
      iv0 = 1'b0; ic0 = '0; id0 = '0; ordy0 = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {63'd0, ov}, 64'd0);
      chk("rst_out_ctrl", {32'd0, oc}, 64'd0);
      chk("rst_out_data", {32'd0, od}, 64'd0);
      chk("rst_occupancy", {62'd0, occ}, 64'd0);
      chk("rst_in_ready", {63'd0, ir}, 64'd1);
      chk("rst_in_ready0", {63'd0, ir0}, 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // back-to-back stream, out_ready high
      ordy = 1'b1;
      iv = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ic = 32'(i + 1); id = 32'h100 + 32'(i);
         @(negedge clk);
         chk("stream_in_ready", {63'd0, ir}, 64'd1);
         if (i > 0) begin
            chk("stream_no_gap", {63'd0, ov}, 64'd1);
            chk("stream_occ", {62'd0, occ}, 64'd1);
         end else begin
            chk("stream_first_empty", {63'd0, ov}, 64'd0);
         end
         @(posedge clk);
         q1.push_back({ic, id});
         #1;
      end
      iv = 1'b0;
      @(negedge clk);
      chk("stream_last_valid", {63'd0, ov}, 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stream_drained", {62'd0, occ}, 64'd0);
      chk("stream_queue_empty", 64'(q1.size()), 64'd0);

      // backpressure fill
      @(posedge clk); #1;
      ordy = 1'b0;
      send(32'd5, 32'hA0);
      send(32'd6, 32'hB0);
      iv = 1'b1; ic = 32'd7; id = 32'hC0;
      @(negedge clk);
      chk("bp_in_ready_full", {63'd0, ir}, 64'd0);
      chk("bp_occ_full", {62'd0, occ}, 64'd2);
      chk("bp_main_ctrl", {32'd0, oc}, 64'd5);
      chk("bp_main_data", {32'd0, od}, 64'hA0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_ctrl", {32'd0, oc}, 64'd5);
      chk("bp_hold_ready", {63'd0, ir}, 64'd0);
      @(posedge clk); #1;
      ordy = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", {63'd0, ir}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_one_ready", {63'd0, ir}, 64'd1);
      chk("bp_one_occ", {62'd0, occ}, 64'd1);
      @(posedge clk);
      q1.push_back({32'd7, 32'hC0});
      #1;
      iv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_queue_empty", 64'(q1.size()), 64'd0);

      // flush with the stage full; ctrl 9 must never emerge
      ordy = 1'b0;
      send(32'h11, 32'h1100);
      send(32'h12, 32'h1200);
      iv = 1'b1; ic = 32'd9; id = 32'h900; flush = 1'b1;
      @(negedge clk);
      chk("fl_occ_before", {62'd0, occ}, 64'd2);
      chk("fl_in_ready", {63'd0, ir}, 64'd0);
      @(posedge clk);
      q1.delete();
      #1;
      flush = 1'b0; iv = 1'b0;
      @(negedge clk);
      chk("fl_out_valid", {63'd0, ov}, 64'd0);
      chk("fl_out_ctrl", {32'd0, oc}, 64'd0);
      chk("fl_out_data", {32'd0, od}, 64'd0);
      chk("fl_occ", {62'd0, occ}, 64'd0);

      // flush in ONE with a firing input beat
      @(posedge clk); #1;
      send(32'h13, 32'h1300);
      iv = 1'b1; ic = 32'h14; id = 32'h1400; flush = 1'b1;
      @(negedge clk);
      chk("fl1_in_ready", {63'd0, ir}, 64'd1);
      @(posedge clk);
      q1.delete();
      #1;
      flush = 1'b0; iv = 1'b0;
      @(negedge clk);
      chk("fl1_occ", {62'd0, occ}, 64'd0);
      @(posedge clk); #1;
      ordy = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // simultaneous in/out in ONE
      iv = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ic = 32'h21 + 32'(i); id = 32'h200 + 32'(i);
         @(negedge clk);
         if (i > 0) begin
            chk("sim_occ", {62'd0, occ}, 64'd1);
            chk("sim_delay_data", {32'd0, od}, {32'd0, 32'h200 + 32'(i - 1)});
         end
         @(posedge clk);
         q1.push_back({ic, id});
         #1;
      end
      iv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("sim_queue_empty", 64'(q1.size()), 64'd0);

      // SKID=0 instance: combinational in_ready
      ordy0 = 1'b0;
      iv0 = 1'b1; ic0 = 32'h31; id0 = 32'h300;
      @(negedge clk);
      chk("s0_ready_empty", {63'd0, ir0}, 64'd1);
      @(posedge clk);
      q0.push_back({32'h31, 32'h300});
      #1;
      ic0 = 32'h32; id0 = 32'h301;
      @(negedge clk);
      chk("s0_ready_stalled", {63'd0, ir0}, 64'd0);
      chk("s0_occ", {62'd0, occ0}, 64'd1);
      @(posedge clk); #1;
      ordy0 = 1'b1;
      #1;
      chk("s0_ready_comb", {63'd0, ir0}, 64'd1);
      @(posedge clk);
      q0.push_back({32'h32, 32'h301});
      #1;
      iv0 = 1'b0;
      @(negedge clk);
      chk("s0_replaced_data", {32'd0, od0}, 64'h301);
      @(posedge clk); #1;
      @(negedge clk);
      chk("s0_drained", {62'd0, occ0}, 64'd0);
      chk("s0_queue_empty", 64'(q0.size()), 64'd0);

      // async reset while full and stalled
      @(posedge clk); #1;
      ordy = 1'b0;
      send(32'h51, 32'h5100);
      send(32'h52, 32'h5200);
      q1.delete();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", {63'd0, ov}, 64'd0);
      chk("ar_out_ctrl", {32'd0, oc}, 64'd0);
      chk("ar_out_data", {32'd0, od}, 64'd0);
      chk("ar_occ", {62'd0, occ}, 64'd0);
      chk("ar_in_ready", {63'd0, ir}, 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ar_after_occ", {62'd0, occ}, 64'd0);

`ifdef PIPE_STAGE_STATS_EN
      @(posedge clk); #1;
      send(32'h61, 32'h6100);
      repeat (3) @(posedge clk);
      #1;
      ordy = 1'b1;
      @(posedge clk); #1;
      flush = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("stat_stall_cnt", {48'd0, stall_cnt}, 64'd3);
      chk("stat_flush_cnt", {48'd0, flush_cnt}, 64'd2);
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("final_queue1", 64'(q1.size()), 64'd0);
      chk("final_queue0", 64'(q0.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline stage register, successor of the fixed ID/EX latch.
- Carries a control bundle and a data bundle between stages with a valid/ready handshake instead of a global Enable.
- Optional one-entry skid buffer gives full throughput with a registered in_ready.
- Flush inserts an all-zero-control bubble; the block is reused for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.

Parameters:
- DATA_W, 32, width of data bundle (operands, immediates, PC)
- CTRL_W, 32, width of control bundle; zero means bubble/NOP
- SKID, 1, 1 = two-entry skid buffer; 0 = single register, in_ready combinational

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous reset, active-high
- flush  in  1  discard all held entries and the current input beat
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts beat
- out_ctrl  out  CTRL_W  control bundle; forced 0 when out_valid=0
- out_data  out  DATA_W  data bundle
- occupancy  out  2  number of held entries, 0..2 (max 1 when SKID=0)

Behaviour:
- Storage: main entry (drives outputs) plus, when SKID=1, a skid entry. Each entry has a valid bit, ctrl and data.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - out_valid = main.valid.
  - out_ctrl = main.valid ? main.ctrl : 0.
- Reset (RESET=1, async): all valid bits, ctrl and data clear to 0.
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=1 (SKID=1) or equals out_ready | ~main.valid (SKID=0).
- SKID=1:
  - in_ready = ~skid.valid (registered, no combinational path from out_ready).
  - States by (main.valid, skid.valid):
    - EMPTY (0,0): in_fire -> load main -> ONE.
    - ONE (1,0):
      - in_fire & out_fire -> main<=in, stay ONE.
      - in_fire & ~out_fire -> skid<=in -> FULL.
      - out_fire & ~in_fire -> EMPTY.
    - FULL (1,1): in_ready=0. out_fire -> main<=skid, skid cleared -> ONE.
  - Order is preserved; a beat is never duplicated or lost.
- SKID=0:
  - in_ready = out_ready | ~main.valid.
  - in_fire loads main; out_fire without in_fire clears main.valid.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Throughput is 1 beat/cycle when out_ready is held high.
- Flush (synchronous, sampled on CLK):
  - Next cycle, all entries are invalid and ctrl=0; data registers also clear to 0.
  - A beat presented with in_fire in the flush cycle is dropped; upstream treats it as accepted.
  - Flush overrides a simultaneous out_fire; the downstream consumed that beat that cycle, so nothing is replayed.
  - in_ready is not gated by flush.
- Stall: while out_ready=0, out_valid/out_ctrl/out_data stay stable. This is a hard requirement, checked by assertion.
- occupancy = main.valid + skid.valid, registered with the state.
- Reset asserted mid-transfer wins over flush and every handshake; no beat survives.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - flush_cnt increments each cycle flush=1.
  - Both saturate at 16'hFFFF and clear on RESET.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then stream: RESET pulse, out_ready=1, push ctrl 1..8 / data 32'h100..32'h107 back-to-back -> out_valid one cycle after first beat, same sequence out with no gaps, occupancy never >1.
- Backpressure fill (SKID=1): out_ready=0, push A=ctrl 5, B=ctrl 6, C=ctrl 7 -> A on outputs, B in skid, in_ready=0 from cycle after B, occupancy=2. Raise out_ready -> A, B, C emerge in order.
- Flush with full stage: FULL state, assert flush with in_valid=1 (ctrl 9) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; ctrl 9 never appears.
- Simultaneous in/out in ONE: hold out_ready=1, in_valid=1 continuously for 4 beats -> occupancy stays 1; out_data matches input delayed by 1 cycle.
- SKID=0 build: out_ready=0 with main valid -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally and the new beat replaces main the next cycle.
- Async reset mid-stall: FULL, assert RESET between clock edges -> outputs 0 immediately, occupancy=0. With PIPE_STAGE_STATS_EN, 3 stalled cycles then 2 flushes -> stall_cnt=3, flush_cnt=2.
